// File: rtl/knns_pkg.sv
// Shared types and defaults for the k-nearest-neighbour top-K sequencer.
// State encoding is fixed so debug taps and other controllers agree on it.
package knns_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StClear  = 2'd1,
    StStream = 2'd2,
    StDone   = 2'd3
  } knns_state_e;

  localparam int unsigned DefW  = 32;
  localparam int unsigned DefK  = 10;
  localparam int unsigned DefCW = 16;

  // A point is {x, y}, so it is twice the coordinate width.
  function automatic int unsigned pt_width(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/knns_ctrl_if.sv
// Generic valid/ready/data channel used for the point stream and the result.
interface knns_ctrl_if #(
  parameter int unsigned DW = 64
) ();

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/knns_beat_cnt.sv
// Beat counter with synchronous clear, enable and a last-beat flag (count == n-1).
module knns_beat_cnt #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] n,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Exit is taken at n-1, so the counter tops out at n and never wraps.
  assign last  = (cnt_q == (n - CW'(1)));
  assign count = cnt_q;

endmodule

// File: rtl/knns_ctrl.sv
// Query sequencer for the top-K datapath: latch query, clear datapath, stream
// n_points candidates, then hold the result until the consumer takes it.
module knns_ctrl
  import knns_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned K  = DefK,
  parameter int unsigned CW = DefCW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CW-1:0]            n_points,
  input  logic [pt_width(W)-1:0]   q_in,
  output logic [pt_width(W)-1:0]   q_out,
  knns_ctrl_if.slave               pt,
  knns_ctrl_if.master              res,
  output logic [pt_width(W)-1:0]   dp_point,
  output logic                     dp_en,
  output logic                     dp_clr,
  input  logic [pt_width(W)*K-1:0] dp_result,
  output logic                     busy,
  output logic [CW-1:0]            count
);

  knns_state_e              state_q;
  logic [pt_width(W)-1:0]   q_q;
  logic [CW-1:0]            n_q;
  logic                     ready_q;
  logic                     clr_q;
  logic                     valid_q;
  logic                     busy_q;

  logic beat;
  logic last;
  logic start_ok;

  assign beat     = pt.valid & ready_q;
  // Abort wins over start, even though abort alone has no effect in idle.
  assign start_ok = (state_q == StIdle) & start & ~abort;

  knns_beat_cnt #(
    .CW (CW)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (beat),
    .n     (n_q),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      n_q     <= '0;
      ready_q <= 1'b0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        ready_q <= 1'b0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_ok) begin
              q_q     <= q_in;
              n_q     <= n_points;
              clr_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StClear;
            end
          end
          StClear: begin
            if (n_q != '0) begin
              ready_q <= 1'b1;
              state_q <= StStream;
            end else begin
              valid_q <= 1'b1;
              state_q <= StDone;
            end
          end
          StStream: begin
            if (beat && last) begin
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              state_q <= StDone;
            end
          end
          StDone: begin
            if (res.ready) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign q_out     = q_q;
  assign pt.ready  = ready_q;
  assign dp_point  = pt.data;
  assign dp_en     = beat;
  assign dp_clr    = clr_q;
  assign res.valid = valid_q;
  assign res.data  = dp_result;
  assign busy      = busy_q;

endmodule

// File: tb/tb_knns_ctrl.sv
// Randomized bench for knns_ctrl against a cycle-timing reference model.
module tb_knns_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned K  = 3;
  localparam int unsigned CW = 6;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned RW = PW * K;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] n_points = '0;
  logic [PW-1:0] q_in = '0;
  logic [PW-1:0] q_out;
  logic [PW-1:0] dp_point;
  logic          dp_en;
  logic          dp_clr;
  logic [RW-1:0] dp_result = '0;
  logic          busy;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  knns_ctrl_if #(.DW(PW)) pt_if ();
  knns_ctrl_if #(.DW(RW)) res_if ();

  knns_ctrl #(
    .W  (W),
    .K  (K),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .n_points  (n_points),
    .q_in      (q_in),
    .q_out     (q_out),
    .pt        (pt_if.slave),
    .res       (res_if.master),
    .dp_point  (dp_point),
    .dp_en     (dp_en),
    .dp_clr    (dp_clr),
    .dp_result (dp_result),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle k counts from the accepted start edge. Stream cycles begin at k=2;
  // the result is valid once all n beats are in, and the query ends on abort or
  // on the result handshake.
  task automatic run_query(input int n, input int vmode, input logic [15:0] vpat,
                           input int abort_beat, input int hold, input logic [PW-1:0] q);
    int  acc = 0;
    int  k   = 1;
    int  hcnt = 0;
    bit  finished = 0;
    bit  exp_rdy, exp_rv, v, r, a;
    logic [PW-1:0] d;
    @(negedge clk);
    start         = 1'b1;
    abort         = 1'b0;
    n_points      = CW'(n);
    q_in          = q;
    pt_if.valid   = 1'($urandom);
    res_if.ready  = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_ready", pt_if.ready, 0);
    @(negedge clk);
    while (!finished && k < 3000) begin
      exp_rdy = (k >= 2) && (acc < n);
      exp_rv  = (k >= 2) && (acc == n);
      if (vmode == 0) v = 1'b1;
      else if (vmode == 1) v = 1'($urandom);
      else v = (k >= 2 && k - 2 < 16) ? vpat[k-2] : 1'b1;
      d            = PW'($urandom);
      pt_if.valid  = v;
      pt_if.data   = d;
      a            = (abort_beat != 0) && exp_rdy && v && (acc == abort_beat - 1);
      abort        = a;
      r            = exp_rv ? ((hcnt >= hold) && ($urandom_range(0, 2) != 0)) : 1'($urandom);
      res_if.ready = r;
      start        = 1'($urandom);
      q_in         = PW'($urandom);
      dp_result    = RW'({$urandom, $urandom});
      #1;
      check("dp_clr", dp_clr, (k == 1));
      check("pt_ready", pt_if.ready, exp_rdy);
      check("res_valid", res_if.valid, exp_rv);
      check("dp_en", dp_en, exp_rdy & v);
      check("dp_point", dp_point, d);
      check("res_data", res_if.data, dp_result);
      check("q_out", q_out, q);
      check("busy", busy, 1);
      check("count", count, acc);
      @(posedge clk);
      if (exp_rdy && v) acc++;
      if (a) finished = 1;
      if (exp_rv && r) finished = 1;
      if (exp_rv) hcnt++;
      @(negedge clk);
      k++;
    end
    if (!finished) check("timeout", 0, 1);
    start       = 1'b0;
    abort       = 1'b0;
    pt_if.valid = 1'($urandom);
    #1;
    check("end_busy", busy, 0);
    check("end_ready", pt_if.ready, 0);
    check("end_valid", res_if.valid, 0);
    check("end_dp_en", dp_en, 0);
    check("end_count", count, acc);
    @(negedge clk);
    #1;
    check("still_idle", busy, 0);
  endtask

  task automatic reset_test();
    @(negedge clk);
    start       = 1'b1;
    n_points    = CW'(8);
    q_in        = PW'(16'h1234);
    pt_if.valid = 1'b1;
    pt_if.data  = PW'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_pre_count", count, 3);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", pt_if.ready, 0);
    check("rst_count", count, 0);
    check("rst_valid", res_if.valid, 0);
    check("rst_q_out", q_out, 0);
    check("rst_dp_en", dp_en, 0);
    @(negedge clk);
    rst         = 1'b1;
    pt_if.valid = 1'b0;
  endtask

  initial begin
    int n, ab;
    pt_if.valid  = 1'b0;
    pt_if.data   = '0;
    res_if.ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("init_busy", busy, 0);
    check("init_ready", pt_if.ready, 0);
    check("init_valid", res_if.valid, 0);
    check("init_clr", dp_clr, 0);
    check("init_count", count, 0);
    check("init_q_out", q_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_query(4, 0, 16'h0, 0, 0, PW'(16'h0507));
    run_query(3, 2, 16'h0029, 0, 0, PW'(16'hA1B2));
    run_query(0, 1, 16'h0, 0, 0, PW'(16'h00FF));
    run_query(5, 0, 16'h0, 2, 0, PW'(16'h3344));
    run_query(1, 0, 16'h0, 0, 0, PW'(16'h5566));
    run_query(4, 1, 16'h0, 0, 10, PW'(16'h7788));
    reset_test();
    run_query(3, 0, 16'h0, 0, 0, PW'(16'h99AA));
    run_query(63, 1, 16'h0, 0, 2, PW'(16'hBEEF));
    run_query(6, 0, 16'h0, 6, 0, PW'(16'hCAFE));
    for (int i = 0; i < 40; i++) begin
      n  = $urandom_range(0, 12);
      ab = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n) : 0;
      run_query(n, 1, 16'h0, ab, $urandom_range(0, 3), PW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
